operand_hazard_ctrl: RTL
========================

Name: operand_hazard_ctrl

Overview:
- Hazard and forwarding controller for register_bank_module in the 5-stage 8-bit MIPS pipeline.
- Tracks the destination registers of in-flight instructions and decodes each incoming 20-bit instruction.
- Drives mux_sel_A, mux_sel_B and imm_sel, and raises stall on load-use hazards.
- Sits between the IF/ID latch and the register bank, alongside the pipeline latches.

Parameters:
- INS_W, 20, instruction width. Fields: [19:15] opcode, [14:10] RW, [9:5] RA, [4:0] RB.
- REG_AW, 5, register address width.
- TRACK_DEPTH, 3, number of in-flight slots tracked (distances 1..3 = EX, DM, WB).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- ins  input  INS_W  instruction in ID; held stable by upstream while stall=1.
- ins_valid  input  1  ins is a real instruction; 0 inserts a bubble.
- mux_sel_A  output  2  A source: 00 regfile, 01 ans_ex, 10 mux_ans_dm, 11 ans_wb.
- mux_sel_B  output  2  B source, same encoding.
- imm_sel  output  1  1 selects imm for B.
- stall  output  1  hold PC and IF/ID; bubble inserted at distance 1.
- RW_dm  output  REG_AW  destination register of the distance-2 slot.
- wb_en  output  1  distance-3 slot writes the register file.
- RW_wb  output  REG_AW  distance-3 destination register.

Behaviour:
- Decode:
  - NOP=5'h00: no write.
  - LOAD=5'h18: writes; marked is_load.
  - STORE=5'h19 and BRANCH=5'h1A: no write.
  - Every other opcode writes RW.
  - Opcode[4]=1 is immediate class: imm_sel=1, and RB is not a source.
- Slot pipeline: three registered slots {valid, writes, is_load, rw}. Each rising edge shifts d1->d2->d3 and discards d3. d1 loads the decoded ins when ins_valid=1 and stall=0, otherwise a bubble (valid=0).
- Forwarding: computed combinationally from ins against the current slots; registered on the edge that accepts ins.
  - For each source, the nearest matching slot wins. Priority: d1 (01) > d2 (10) > d3 (11).
  - A slot matches only if valid=1 and writes=1; otherwise the select is 00.
  - RA==RB yields identical selects.
  - Unused RB forces mux_sel_B=00.
- Outputs are held during stall. Latency is 1 cycle from ins acceptance to valid selects.
- FSM, states RUN and STALL:
  - RUN -> STALL when ins_valid=1 and d1 is a valid load whose rw matches a used source. stall is asserted combinationally in that cycle and a bubble enters d1.
  - STALL -> RUN after one cycle. The load is now at d2 and forwards via 10.
- Reset (any time, including mid-stall): all slots invalid; state RUN; mux_sel_A=mux_sel_B=00; imm_sel=0; stall=0; RW_dm=0; wb_en=0; RW_wb=0.
- ins_valid=0: no hazard check; bubble shifted in; selects retain their value.

Optional Feature:
- Macro HAZARD_FWD_EN.
- Defined: forwarding and the 1-cycle load-use stall exactly as above.
- Undefined:
  - Selects are always 00.
  - Any RAW match against d1..d3 stalls. A 2-bit counter loads 3 minus the nearest matching distance plus 1, and the unit stays in STALL until the producer has retired past d3.
  - Example: a match at d1 stalls 3 cycles.

Decomposition:
- Shared package hazard_pkg:
  - Opcode constants OP_NOP, OP_LOAD, OP_STORE, OP_BRANCH.
  - Select encodings SEL_RF, SEL_EX, SEL_DM, SEL_WB.
  - Slot struct typedef.
  - Field index localparams.
- One natural sub-module: ins_decode (combinational opcode/field decode to writes, is_load, uses_rb, imm_sel).

Test Plan:
- Reset low with ins=20'h00000 -> all outputs 0 and stall=0; release reset -> still 0.
- ADD R5<-R1,R2 then ADD R6<-R5,R5 back-to-back -> second issue gives mux_sel_A=mux_sel_B=01, stall=0.
- ADD R5<-..., NOP, SUB R7<-R3,R5 -> mux_sel_A=00, mux_sel_B=10; with two NOPs, mux_sel_B=11.
- LOAD R4 then ADD R8<-R4,R1 -> stall=1 for exactly one cycle, bubble at d1; next cycle mux_sel_A=10.
- Immediate opcode 5'h14 with RB=R5 while R5 sits in d1 -> imm_sel=1, mux_sel_B=00, no stall.
- Reset asserted during a load-use stall -> stall drops immediately, slots cleared; HAZARD_FWD_EN undefined: the ADD R5 / ADD R6 pair stalls 3 cycles with selects 00.

Source files
------------

// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the operand hazard / forwarding controller:
// instruction field positions, opcode constants, operand-select encodings,
// the in-flight slot record and the nearest-producer search used by both the
// forwarding and the stall logic.
// -----------------------------------------------------------------------------
package hazard_pkg;

   localparam int INS_W       = 20;
   localparam int REG_AW      = 5;
   localparam int TRACK_DEPTH = 3;

   // Instruction fields: [19:15] opcode, [14:10] RW, [9:5] RA, [4:0] RB
   localparam int OP_MSB = 19;
   localparam int OP_LSB = 15;
   localparam int RW_MSB = 14;
   localparam int RW_LSB = 10;
   localparam int RA_MSB = 9;
   localparam int RA_LSB = 5;
   localparam int RB_MSB = 4;
   localparam int RB_LSB = 0;
   localparam int OP_W   = OP_MSB - OP_LSB + 1;

   localparam logic [OP_W-1:0] OP_NOP    = 5'h00;
   localparam logic [OP_W-1:0] OP_LOAD   = 5'h18;
   localparam logic [OP_W-1:0] OP_STORE  = 5'h19;
   localparam logic [OP_W-1:0] OP_BRANCH = 5'h1A;

   // Operand source select; the code equals the producer's distance
   localparam logic [1:0] SEL_RF = 2'b00;
   localparam logic [1:0] SEL_EX = 2'b01;
   localparam logic [1:0] SEL_DM = 2'b10;
   localparam logic [1:0] SEL_WB = 2'b11;

   typedef struct packed {
      logic              valid;
      logic              writes;
      logic              is_load;
      logic [REG_AW-1:0] rw;
   } slot_t;

   // Element 0 is distance 1 (EX), element 2 is distance 3 (WB)
   typedef slot_t slot_arr_t [TRACK_DEPTH];

   // Select of the nearest valid writer of src, SEL_RF if none.
   // Scanning from the far end lets a nearer match overwrite a farther one.
   function automatic logic [1:0] nearest_sel(input slot_arr_t slots,
                                              input logic [REG_AW-1:0] src);
      logic [1:0] sel;
      sel = SEL_RF;
      for (int k = TRACK_DEPTH - 1; k >= 0; k--) begin
         if (slots[k].valid && slots[k].writes && (slots[k].rw == src))
            sel = 2'(k + 1);
      end
      return sel;
   endfunction

endpackage

// File: rtl/operand_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// operand_hazard_ctrl_if
// Decode-stage bundle between the IF/ID side and the hazard controller.
//   master : drives ins / ins_valid, observes selects, stall, WB info
//   slave  : the controller (operand_hazard_ctrl)
// -----------------------------------------------------------------------------
interface operand_hazard_ctrl_if;

   logic [hazard_pkg::INS_W-1:0]  ins;
   logic                          ins_valid;
   logic [1:0]                    mux_sel_A;
   logic [1:0]                    mux_sel_B;
   logic                          imm_sel;
   logic                          stall;
   logic [hazard_pkg::REG_AW-1:0] RW_dm;
   logic                          wb_en;
   logic [hazard_pkg::REG_AW-1:0] RW_wb;

   modport master (
      output ins, ins_valid,
      input  mux_sel_A, mux_sel_B, imm_sel, stall, RW_dm, wb_en, RW_wb
   );

   modport slave (
      input  ins, ins_valid,
      output mux_sel_A, mux_sel_B, imm_sel, stall, RW_dm, wb_en, RW_wb
   );

endinterface

// File: rtl/operand_hazard_ctrl_ins_decode.sv
// -----------------------------------------------------------------------------
// ins_decode
// Pure combinational decode of one instruction into the slot record it will
// occupy once accepted, plus its source-operand usage.
//   ins     : instruction word in ID
//   dec     : {valid=1, writes, is_load, rw}
//   ra, rb  : source register fields
//   uses_rb : RB is a real source (register class only)
//   imm_sel : immediate class (opcode MSB set)
// -----------------------------------------------------------------------------
module ins_decode
   import hazard_pkg::*;
(
   input  logic [INS_W-1:0]  ins,
   output slot_t             dec,
   output logic [REG_AW-1:0] ra,
   output logic [REG_AW-1:0] rb,
   output logic              uses_rb,
   output logic              imm_sel
);

   logic [OP_W-1:0] opcode;

   assign opcode  = ins[OP_MSB:OP_LSB];
   assign ra      = ins[RA_MSB:RA_LSB];
   assign rb      = ins[RB_MSB:RB_LSB];
   assign imm_sel = opcode[OP_W-1];
   assign uses_rb = ~opcode[OP_W-1];

   assign dec.valid   = 1'b1;
   assign dec.writes  = !((opcode == OP_NOP) || (opcode == OP_STORE) ||
                          (opcode == OP_BRANCH));
   assign dec.is_load = (opcode == OP_LOAD);
   assign dec.rw      = ins[RW_MSB:RW_LSB];

endmodule

// File: rtl/operand_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// operand_hazard_ctrl
// Tracks the destinations of the three in-flight instructions (EX, DM, WB),
// forwards operands to the instruction in ID and stalls on hazards.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : operand_hazard_ctrl_if.slave (ins, ins_valid in; selects,
//           imm_sel, stall, RW_dm, wb_en, RW_wb out)
// Build option HAZARD_FWD_EN:
//   defined   - forwarding selects, one-cycle stall on load-use only
//   undefined - selects stay 00, any RAW stalls until the producer leaves WB
// -----------------------------------------------------------------------------
module operand_hazard_ctrl
   import hazard_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   operand_hazard_ctrl_if.slave  bus
);

   localparam logic [0:0] ST_RUN   = 1'b0;
   localparam logic [0:0] ST_STALL = 1'b1;

   slot_arr_t         slot_q, slot_d;
   logic [0:0]        state_q, state_d;
   logic [1:0]        sel_a_q, sel_a_d;
   logic [1:0]        sel_b_q, sel_b_d;
   logic              imm_q, imm_d;
`ifndef HAZARD_FWD_EN
   logic [1:0]        cnt_q, cnt_d;
   logic [1:0]        near_sel;
   logic              raw_hit;
`else
   logic              load_use;
`endif

   slot_t             dec;
   logic [REG_AW-1:0] ra, rb;
   logic              uses_rb, dec_imm;
   logic [1:0]        sel_a_raw, sel_b_raw;
   logic              stall_int, accept;

   ins_decode u_decode (
      .ins     (bus.ins),
      .dec     (dec),
      .ra      (ra),
      .rb      (rb),
      .uses_rb (uses_rb),
      .imm_sel (dec_imm)
   );

   assign sel_a_raw = nearest_sel(slot_q, ra);
   assign sel_b_raw = uses_rb ? nearest_sel(slot_q, rb) : SEL_RF;

`ifndef HAZARD_FWD_EN
   assign raw_hit  = bus.ins_valid && ((sel_a_raw != SEL_RF) || (sel_b_raw != SEL_RF));
   // Nearest producer over both sources; the smaller non-zero code wins
   assign near_sel = ((sel_a_raw != SEL_RF) &&
                      ((sel_b_raw == SEL_RF) || (sel_a_raw < sel_b_raw))) ? sel_a_raw
                                                                         : sel_b_raw;
`else
   // A match at distance 1 implies that slot is valid and writes
   assign load_use = bus.ins_valid && slot_q[0].is_load &&
                     ((sel_a_raw == SEL_EX) || (sel_b_raw == SEL_EX));
`endif

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can
      // leave it unassigned and infer a latch.
      state_d   = state_q;
      stall_int = 1'b0;
`ifdef HAZARD_FWD_EN
      case (state_q)
         ST_RUN: begin
            if (load_use) begin
               stall_int = 1'b1;
               state_d   = ST_STALL;
            end
         end
         // The load has moved to DM behind the bubble and now forwards
         default: state_d = ST_RUN;
      endcase
`else
      cnt_d = cnt_q;
      case (state_q)
         ST_RUN: begin
            if (raw_hit) begin
               stall_int = 1'b1;
               // Total stall length is 4 - distance; a WB producer needs only
               // this detecting cycle, so STALL is skipped for it.
               if (near_sel != SEL_WB) begin
                  state_d = ST_STALL;
                  cnt_d   = 2'(3'd4 - {1'b0, near_sel});
               end
            end
         end
         default: begin
            stall_int = 1'b1;
            cnt_d     = cnt_q - 2'd1;
            if (cnt_q == 2'd2) state_d = ST_RUN;
         end
      endcase
`endif

      accept = bus.ins_valid && !stall_int;

      slot_d[0] = accept ? dec : '0;
      slot_d[1] = slot_q[0];
      slot_d[2] = slot_q[1];

      sel_a_d = sel_a_q;
      sel_b_d = sel_b_q;
      imm_d   = imm_q;
      if (accept) begin
`ifdef HAZARD_FWD_EN
         sel_a_d = sel_a_raw;
         sel_b_d = sel_b_raw;
`else
         sel_a_d = SEL_RF;
         sel_b_d = SEL_RF;
`endif
         imm_d = dec_imm;
      end
   end

   // NOTE: sequential state is updated with non-blocking assignments only, so
   // every flop samples the pre-edge value of its neighbours.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         slot_q  <= '{default: '0};
         state_q <= ST_RUN;
         sel_a_q <= SEL_RF;
         sel_b_q <= SEL_RF;
         imm_q   <= 1'b0;
`ifndef HAZARD_FWD_EN
         cnt_q   <= 2'd0;
`endif
      end else begin
         slot_q  <= slot_d;
         state_q <= state_d;
         sel_a_q <= sel_a_d;
         sel_b_q <= sel_b_d;
         imm_q   <= imm_d;
`ifndef HAZARD_FWD_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign bus.mux_sel_A = sel_a_q;
   assign bus.mux_sel_B = sel_b_q;
   assign bus.imm_sel   = imm_q;
   assign bus.stall     = stall_int;
   assign bus.RW_dm     = slot_q[1].rw;
   assign bus.wb_en     = slot_q[2].valid && slot_q[2].writes;
   assign bus.RW_wb     = slot_q[2].rw;

endmodule
